// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory read/write channel between NR read requesters and a single
// write requester, with exactly one transaction outstanding at a time.
// Reads are served round-robin. Writes win arbitration, but only for a limited
// streak while any read is waiting, so pending reads cannot be starved.
// Every output comes straight from a register.
module mem_port_arbiter #(
   parameter int NR            = 2,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int LEN_W         = 2,
   parameter int WR_STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NR-1:0]        c_re,
   input  logic [NR*ADDR_W-1:0] c_raddr,
   input  logic [NR*LEN_W-1:0]  c_rlen,
   output logic [NR*DATA_W-1:0] c_dout,
   output logic [NR-1:0]        c_rack,
   input  logic                 c_we,
   input  logic [ADDR_W-1:0]    c_waddr,
   input  logic [LEN_W-1:0]     c_wlen,
   input  logic [DATA_W-1:0]    c_din,
   output logic                 c_wack,
   output logic                 m_re,
   output logic [ADDR_W-1:0]    m_raddr,
   output logic [LEN_W-1:0]     m_rlen,
   input  logic [DATA_W-1:0]    m_din,
   input  logic                 m_rack,
   output logic                 m_we,
   output logic [ADDR_W-1:0]    m_waddr,
   output logic [LEN_W-1:0]     m_wlen,
   output logic [DATA_W-1:0]    m_dout,
   input  logic                 m_wack,
   output logic                 busy
);

   localparam int PW = (NR > 1) ? $clog2(NR) : 1;
   localparam int SW = $clog2(WR_STARVE_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(WR_STARVE_MAX);
   localparam logic [PW-1:0] RR_RESET   = PW'(NR - 1);

   typedef enum logic [2:0] {
      IDLE,
      R_WAIT,
      R_RESP,
      W_WAIT,
      W_RESP
   } state_t;

   state_t state_reg, state_next;

   logic [PW-1:0]     port_reg, port_next;
   logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [SW-1:0]     wr_streak_reg, wr_streak_next;
   logic              m_re_reg, m_re_next;
   logic [ADDR_W-1:0] m_raddr_reg, m_raddr_next;
   logic [LEN_W-1:0]  m_rlen_reg, m_rlen_next;
   logic              m_we_reg, m_we_next;
   logic [ADDR_W-1:0] m_waddr_reg, m_waddr_next;
   logic [LEN_W-1:0]  m_wlen_reg, m_wlen_next;
   logic [DATA_W-1:0] m_dout_reg, m_dout_next;
   logic [NR-1:0]     c_rack_reg, c_rack_next;
   logic              c_wack_reg, c_wack_next;
   logic              busy_reg, busy_next;
   logic              rd_done;

   logic [ADDR_W-1:0] raddr_lane [NR];
   logic [LEN_W-1:0]  rlen_lane  [NR];
   logic [DATA_W-1:0] c_dout_reg [NR];

   logic              rd_found;
   logic [PW-1:0]     rd_idx;

   // Unpack the flat per-port buses and pack the per-port read data lanes.
   // Each lane only changes when a read for its own port completes.
   for (genvar gi = 0; gi < NR; gi++) begin : g_lane
      assign raddr_lane[gi] = c_raddr[gi*ADDR_W +: ADDR_W];
      assign rlen_lane[gi]  = c_rlen[gi*LEN_W +: LEN_W];
      assign c_dout[gi*DATA_W +: DATA_W] = c_dout_reg[gi];

      // Capture memory read data into this lane when its read finishes.
      always_ff @(posedge clk) begin
         if (rst) begin
            c_dout_reg[gi] <= '0;
         end else if (rd_done && (port_reg == PW'(gi))) begin
            c_dout_reg[gi] <= m_din;
         end
      end
   end

   // Round-robin search: first asserted read request after the last granted port.
   always_comb begin
      int            cand;
      logic [PW-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      rd_found = 1'b0;
      rd_idx   = '0;
      for (int k = 1; k <= NR; k++) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= NR) begin
            cand = cand - NR;
         end
         cand_idx = PW'(cand);
         if (!rd_found && c_re[cand_idx]) begin
            rd_found = 1'b1;
            rd_idx   = cand_idx;
         end
      end
   end

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      state_next     = state_reg;
      port_next      = port_reg;
      rr_ptr_next    = rr_ptr_reg;
      wr_streak_next = wr_streak_reg;
      m_re_next      = m_re_reg;
      m_raddr_next   = m_raddr_reg;
      m_rlen_next    = m_rlen_reg;
      m_we_next      = m_we_reg;
      m_waddr_next   = m_waddr_reg;
      m_wlen_next    = m_wlen_reg;
      m_dout_next    = m_dout_reg;
      c_rack_next    = '0;
      c_wack_next    = 1'b0;
      rd_done        = 1'b0;

      case (state_reg)
         IDLE: begin
            // The write wins unless reads are waiting and the write streak is used up.
            if (c_we && (!rd_found || (wr_streak_reg < STREAK_MAX))) begin
               if (rd_found) begin
                  wr_streak_next = wr_streak_reg + SW'(1);
               end
               m_we_next    = 1'b1;
               m_waddr_next = c_waddr;
               m_wlen_next  = c_wlen;
               m_dout_next  = c_din;
               state_next   = W_WAIT;
            end else if (rd_found) begin
               port_next      = rd_idx;
               rr_ptr_next    = rd_idx;
               wr_streak_next = '0;
               m_re_next      = 1'b1;
               m_raddr_next   = raddr_lane[rd_idx];
               m_rlen_next    = rlen_lane[rd_idx];
               state_next     = R_WAIT;
            end
         end
         R_WAIT: begin
            if (m_rack) begin
               rd_done               = 1'b1;
               m_re_next             = 1'b0;
               c_rack_next[port_reg] = 1'b1;
               state_next            = R_RESP;
            end
         end
         R_RESP: begin
            state_next = IDLE;
         end
         W_WAIT: begin
            if (m_wack) begin
               m_we_next   = 1'b0;
               c_wack_next = 1'b1;
               state_next  = W_RESP;
            end
         end
         W_RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // State and registered-output update; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         port_reg      <= '0;
         rr_ptr_reg    <= RR_RESET;
         wr_streak_reg <= '0;
         m_re_reg      <= 1'b0;
         m_raddr_reg   <= '0;
         m_rlen_reg    <= '0;
         m_we_reg      <= 1'b0;
         m_waddr_reg   <= '0;
         m_wlen_reg    <= '0;
         m_dout_reg    <= '0;
         c_rack_reg    <= '0;
         c_wack_reg    <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         port_reg      <= port_next;
         rr_ptr_reg    <= rr_ptr_next;
         wr_streak_reg <= wr_streak_next;
         m_re_reg      <= m_re_next;
         m_raddr_reg   <= m_raddr_next;
         m_rlen_reg    <= m_rlen_next;
         m_we_reg      <= m_we_next;
         m_waddr_reg   <= m_waddr_next;
         m_wlen_reg    <= m_wlen_next;
         m_dout_reg    <= m_dout_next;
         c_rack_reg    <= c_rack_next;
         c_wack_reg    <= c_wack_next;
         busy_reg      <= busy_next;
      end
   end

   assign m_re    = m_re_reg;
   assign m_raddr = m_raddr_reg;
   assign m_rlen  = m_rlen_reg;
   assign m_we    = m_we_reg;
   assign m_waddr = m_waddr_reg;
   assign m_wlen  = m_wlen_reg;
   assign m_dout  = m_dout_reg;
   assign c_rack  = c_rack_reg;
   assign c_wack  = c_wack_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic compared against an arbitration and data model.
module tb_mem_port_arbiter;

   localparam int NR     = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 2;
   localparam int WSM    = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NR-1:0]        c_re;
   logic [NR*ADDR_W-1:0] c_raddr;
   logic [NR*LEN_W-1:0]  c_rlen;
   logic [NR*DATA_W-1:0] c_dout;
   logic [NR-1:0]        c_rack;
   logic                 c_we;
   logic [ADDR_W-1:0]    c_waddr;
   logic [LEN_W-1:0]     c_wlen;
   logic [DATA_W-1:0]    c_din;
   logic                 c_wack;
   logic                 m_re;
   logic [ADDR_W-1:0]    m_raddr;
   logic [LEN_W-1:0]     m_rlen;
   logic [DATA_W-1:0]    m_din;
   logic                 m_rack;
   logic                 m_we;
   logic [ADDR_W-1:0]    m_waddr;
   logic [LEN_W-1:0]     m_wlen;
   logic [DATA_W-1:0]    m_dout;
   logic                 m_wack;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mem_port_arbiter #(
      .NR(NR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WR_STARVE_MAX(WSM)
   ) dut (
      .clk(clk), .rst(rst),
      .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen), .c_dout(c_dout), .c_rack(c_rack),
      .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen), .c_din(c_din), .c_wack(c_wack),
      .m_re(m_re), .m_raddr(m_raddr), .m_rlen(m_rlen), .m_din(m_din), .m_rack(m_rack),
      .m_we(m_we), .m_waddr(m_waddr), .m_wlen(m_wlen), .m_dout(m_dout), .m_wack(m_wack),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      c_re = '0; c_raddr = '0; c_rlen = '0; c_we = 1'b0;
      c_waddr = '0; c_wlen = '0; c_din = '0;
      m_din = '0; m_rack = 1'b0; m_wack = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Acts as the memory for one transaction: waits (bounded) for a grant,
   // holds off for 'delay' extra cycles, then acks. Only observes; callers judge.
   task automatic mem_serve(input int delay, input logic [DATA_W-1:0] rdata, input bit stray,
                            output bit got, output bit was_wr,
                            output logic [ADDR_W-1:0] addr, output logic [LEN_W-1:0] len,
                            output logic [DATA_W-1:0] wdata, output int hi, output bit held,
                            output int gcyc, output logic [NR-1:0] rack, output logic wack,
                            output bit rel);
      got = 1'b0; was_wr = 1'b0; addr = '0; len = '0; wdata = '0;
      hi = 0; held = 1'b1; gcyc = 0; rack = '0; wack = 1'b0; rel = 1'b0;
      for (int i = 0; i < 16 && !(m_re || m_we); i++) step();
      if (!(m_re || m_we)) return;
      got    = 1'b1;
      was_wr = m_we;
      gcyc   = cyc;
      addr   = was_wr ? m_waddr : m_raddr;
      len    = was_wr ? m_wlen : m_rlen;
      wdata  = m_dout;
      for (int d = 0; d <= delay; d++) begin
         if (d > 0) step();
         if (was_wr ? m_we : m_re) hi++;
         if (was_wr) begin
            if (m_waddr !== addr || m_wlen !== len || m_dout !== wdata) held = 1'b0;
            m_rack = stray;
         end else begin
            if (m_raddr !== addr || m_rlen !== len) held = 1'b0;
            m_wack = stray;
         end
      end
      if (was_wr) begin
         m_wack = 1'b1;
      end else begin
         m_rack = 1'b1;
         m_din  = rdata;
      end
      step();
      m_rack = 1'b0;
      m_wack = 1'b0;
      rack = c_rack;
      wack = c_wack;
      rel  = !(m_re || m_we);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (m_re !== 1'b0)   begin n_fail++; $display("FAIL reset_m_re got %b want 0", m_re); end
      n_checks++; if (m_we !== 1'b0)   begin n_fail++; $display("FAIL reset_m_we got %b want 0", m_we); end
      n_checks++; if (c_rack !== '0)   begin n_fail++; $display("FAIL reset_c_rack got %b want 0", c_rack); end
      n_checks++; if (c_wack !== 1'b0) begin n_fail++; $display("FAIL reset_c_wack got %b want 0", c_wack); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (c_dout !== '0)   begin n_fail++; $display("FAIL reset_c_dout got %h want 0", c_dout); end
      n_checks++; if (m_raddr !== '0 || m_waddr !== '0 || m_dout !== '0 || m_rlen !== '0 || m_wlen !== '0)
         begin n_fail++; $display("FAIL reset_m_bus got raddr=%h waddr=%h dout=%h want all 0", m_raddr, m_waddr, m_dout); end
      $display("reset: outputs checked");
   endtask

   task automatic test_single_read();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc; logic [NR-1:0] rk; logic wk;
      do_reset();
      c_raddr = {32'h0000_0200, 32'h0000_0100};
      c_rlen  = {2'd1, 2'd3};
      c_re    = 2'b01;
      mem_serve(1, 32'hDEAD_BEEF, 1'b0, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
      c_re = '0;
      $display("single read: addr=%h len=%0d rack=%b", a, l, rk);
      n_checks++; if (got !== 1'b1 || wr !== 1'b0) begin n_fail++; $display("FAIL single_grant got got=%b wr=%b want 1/0", got, wr); end
      n_checks++; if (a !== 32'h100)  begin n_fail++; $display("FAIL single_addr got %h want 100", a); end
      n_checks++; if (l !== 2'd3)     begin n_fail++; $display("FAIL single_len got %0d want 3", l); end
      n_checks++; if (hi !== 2)       begin n_fail++; $display("FAIL single_re_cycles got %0d want 2", hi); end
      n_checks++; if (rk !== 2'b01)   begin n_fail++; $display("FAIL single_rack got %b want 01", rk); end
      n_checks++; if (rel !== 1'b1)   begin n_fail++; $display("FAIL single_m_re_drop got %b want 1", rel); end
      n_checks++; if (c_dout[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_lane0 got %h want deadbeef", c_dout[31:0]); end
      n_checks++; if (c_dout[63:32] !== 32'h0) begin n_fail++; $display("FAIL single_lane1 got %h want 0", c_dout[63:32]); end
      step();
      n_checks++; if (c_rack !== 2'b00) begin n_fail++; $display("FAIL single_rack_pulse got %b want 00", c_rack); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL single_busy_idle got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc, prev; logic [NR-1:0] rk, exp_rk; logic wk;
      do_reset();
      c_raddr = {32'h0000_0020, 32'h0000_0010};
      c_rlen  = {2'd2, 2'd1};
      c_re    = 2'b11;
      prev    = 0;
      for (int t = 0; t < 4; t++) begin
         mem_serve(0, DATA_W'(t + 1), 1'b0, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
         exp_rk = (t % 2 == 0) ? 2'b01 : 2'b10;
         $display("round robin txn %0d: rack=%b addr=%h cycle=%0d", t, rk, a, gc);
         n_checks++; if (rk !== exp_rk) begin n_fail++; $display("FAIL rr_order_%0d got %b want %b", t, rk, exp_rk); end
         n_checks++; if (a !== ((t % 2 == 0) ? 32'h10 : 32'h20)) begin n_fail++; $display("FAIL rr_addr_%0d got %h", t, a); end
         if (t > 0) begin
            n_checks++; if (gc - prev !== 3) begin n_fail++; $display("FAIL rr_spacing_%0d got %0d want 3", t, gc - prev); end
         end
         prev = gc;
      end
      c_re = '0;
      step();
      step();
   endtask

   task automatic test_write_starve();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc; logic [NR-1:0] rk; logic wk; bit exp_wr;
      do_reset();
      c_raddr = {32'h0, 32'h0000_0400};
      c_re    = 2'b01;
      c_we    = 1'b1;
      c_waddr = 32'h0000_0800;
      c_wlen  = 2'd2;
      for (int t = 0; t < 9; t++) begin
         c_din = 32'hC000_0000 + DATA_W'(t);
         mem_serve(0, 32'h5555_0000 + DATA_W'(t), 1'b0, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
         exp_wr = (t != 4);
         $display("starve txn %0d: %s addr=%h", t, wr ? "write" : "read", a);
         n_checks++; if (wr !== exp_wr) begin n_fail++; $display("FAIL starve_kind_%0d got wr=%b want %b", t, wr, exp_wr); end
         if (exp_wr) begin
            n_checks++; if (wk !== 1'b1 || rk !== 2'b00) begin n_fail++; $display("FAIL starve_wack_%0d got wack=%b rack=%b", t, wk, rk); end
            n_checks++; if (wd !== 32'hC000_0000 + DATA_W'(t)) begin n_fail++; $display("FAIL starve_wdata_%0d got %h", t, wd); end
         end else begin
            n_checks++; if (rk !== 2'b01 || wk !== 1'b0) begin n_fail++; $display("FAIL starve_rack_%0d got rack=%b wack=%b", t, rk, wk); end
         end
      end
      c_re = '0;
      c_we = 1'b0;
      step();
      step();
   endtask

   task automatic test_simultaneous();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc; logic [NR-1:0] rk; logic wk;
      do_reset();
      c_raddr = {32'h0000_0A00, 32'h0};
      c_rlen  = {2'd3, 2'd0};
      c_we    = 1'b1;
      c_waddr = 32'h0000_0B00;
      c_wlen  = 2'd1;
      c_din   = 32'h1234_5678;
      c_re    = 2'b10;
      mem_serve(0, 32'h0, 1'b0, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
      c_we = 1'b0;
      $display("simultaneous txn 0: %s addr=%h", wr ? "write" : "read", a);
      n_checks++; if (wr !== 1'b1 || wk !== 1'b1) begin n_fail++; $display("FAIL simul_write_first got wr=%b wack=%b want 1/1", wr, wk); end
      n_checks++; if (a !== 32'hB00 || l !== 2'd1 || wd !== 32'h1234_5678) begin n_fail++; $display("FAIL simul_wfields got %h/%0d/%h", a, l, wd); end
      mem_serve(2, 32'h0BAD_F00D, 1'b1, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
      c_re = '0;
      $display("simultaneous txn 1: %s addr=%h rack=%b", wr ? "write" : "read", a, rk);
      n_checks++; if (wr !== 1'b0 || rk !== 2'b10) begin n_fail++; $display("FAIL simul_read_second got wr=%b rack=%b want 0/10", wr, rk); end
      n_checks++; if (a !== 32'hA00 || l !== 2'd3) begin n_fail++; $display("FAIL simul_rfields got %h/%0d want a00/3", a, l); end
      n_checks++; if (c_dout !== {32'h0BAD_F00D, 32'h0}) begin n_fail++; $display("FAIL simul_dout got %h", c_dout); end
      step();
   endtask

   task automatic test_reset_mid_read();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc; logic [NR-1:0] rk; logic wk;
      do_reset();
      c_raddr = {32'h0000_0700, 32'h0000_0300};
      c_re    = 2'b01;
      step();
      n_checks++; if (m_re !== 1'b1) begin n_fail++; $display("FAIL midrst_started got m_re=%b want 1", m_re); end
      step();
      rst  = 1'b1;
      c_re = '0;
      step();
      rst    = 1'b0;
      m_rack = 1'b1;
      m_din  = 32'hAAAA_5555;
      n_checks++; if (m_re !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_abort got m_re=%b busy=%b want 0/0", m_re, busy); end
      step();
      m_rack = 1'b0;
      n_checks++; if (c_rack !== '0) begin n_fail++; $display("FAIL midrst_no_ack got %b want 00", c_rack); end
      n_checks++; if (c_dout !== '0) begin n_fail++; $display("FAIL midrst_dout got %h want 0", c_dout); end
      n_checks++; if (busy !== 1'b0 || m_re !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%b m_re=%b", busy, m_re); end
      c_re = 2'b10;
      mem_serve(0, 32'h0000_1234, 1'b0, got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
      c_re = '0;
      $display("after reset txn: rack=%b addr=%h", rk, a);
      n_checks++; if (got !== 1'b1 || rk !== 2'b10 || a !== 32'h700) begin n_fail++; $display("FAIL midrst_next got got=%b rack=%b addr=%h", got, rk, a); end
      n_checks++; if (c_dout !== {32'h0000_1234, 32'h0}) begin n_fail++; $display("FAIL midrst_next_dout got %h", c_dout); end
      step();
   endtask

   task automatic test_stray_ack();
      do_reset();
      m_rack = 1'b1;
      m_wack = 1'b1;
      m_din  = 32'hFFFF_FFFF;
      step();
      m_rack = 1'b0;
      m_wack = 1'b0;
      n_checks++; if (c_rack !== '0 || c_wack !== 1'b0) begin n_fail++; $display("FAIL stray_acks got rack=%b wack=%b want 0/0", c_rack, c_wack); end
      n_checks++; if (busy !== 1'b0 || m_re !== 1'b0 || m_we !== 1'b0) begin n_fail++; $display("FAIL stray_busy got busy=%b", busy); end
      step();
      n_checks++; if (c_rack !== '0 || c_dout !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_after got rack=%b dout=%h", c_rack, c_dout); end
      $display("stray ack: ignored");
   endtask

   task automatic test_random();
      bit got, wr, held, rel; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; logic [DATA_W-1:0] wd;
      int hi, gc; logic [NR-1:0] rk; logic wk;
      logic [DATA_W-1:0] exp_lane [NR];
      logic [NR-1:0] re;
      logic we;
      int model_rr, model_streak, exp_idx, delay;
      bit exp_wr;
      logic [ADDR_W-1:0] exp_addr;
      logic [LEN_W-1:0] exp_len;
      logic [DATA_W-1:0] rdata;
      do_reset();
      model_rr = NR - 1;
      model_streak = 0;
      for (int i = 0; i < NR; i++) exp_lane[i] = '0;
      for (int n = 0; n < 40; n++) begin
         re = NR'($urandom_range(0, (1 << NR) - 1));
         we = 1'($urandom_range(0, 1));
         if (re == '0 && !we) we = 1'b1;
         for (int i = 0; i < NR; i++) begin
            c_raddr[i*ADDR_W +: ADDR_W] = $urandom;
            c_rlen[i*LEN_W +: LEN_W]    = LEN_W'($urandom_range(0, 3));
         end
         c_waddr = $urandom;
         c_wlen  = LEN_W'($urandom_range(0, 3));
         c_din   = $urandom;
         rdata   = $urandom;
         delay   = $urandom_range(0, 3);
         exp_idx = -1;
         if (we && (re == '0 || model_streak < WSM)) begin
            exp_wr = 1'b1;
            if (re != '0) model_streak++;
            exp_addr = c_waddr;
            exp_len  = c_wlen;
         end else begin
            exp_wr = 1'b0;
            for (int k = 1; k <= NR; k++) begin
               if (exp_idx < 0 && re[(model_rr + k) % NR]) exp_idx = (model_rr + k) % NR;
            end
            model_rr = exp_idx;
            model_streak = 0;
            exp_addr = c_raddr[exp_idx*ADDR_W +: ADDR_W];
            exp_len  = c_rlen[exp_idx*LEN_W +: LEN_W];
            exp_lane[exp_idx] = rdata;
         end
         c_re = re;
         c_we = we;
         mem_serve(delay, rdata, 1'($urandom_range(0, 1)), got, wr, a, l, wd, hi, held, gc, rk, wk, rel);
         c_re = '0;
         c_we = 1'b0;
         $display("txn %0d: re=%b we=%b -> %s port %0d addr=%h len=%0d delay=%0d",
                  n, re, we, wr ? "write" : "read", exp_idx, a, l, delay);
         n_checks++; if (got !== 1'b1 || wr !== exp_wr) begin n_fail++; $display("FAIL rand_kind_%0d got got=%b wr=%b want wr=%b", n, got, wr, exp_wr); end
         n_checks++; if (a !== exp_addr || l !== exp_len) begin n_fail++; $display("FAIL rand_fields_%0d got %h/%0d want %h/%0d", n, a, l, exp_addr, exp_len); end
         n_checks++; if (hi !== delay + 1 || held !== 1'b1) begin n_fail++; $display("FAIL rand_hold_%0d got hi=%0d held=%b want %0d/1", n, hi, held, delay + 1); end
         n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL rand_release_%0d got %b want 1", n, rel); end
         if (exp_wr) begin
            n_checks++; if (wk !== 1'b1 || rk !== '0 || wd !== c_din) begin n_fail++; $display("FAIL rand_wack_%0d got wack=%b rack=%b data=%h want %h", n, wk, rk, wd, c_din); end
         end else begin
            n_checks++; if (rk !== NR'(1 << exp_idx) || wk !== 1'b0) begin n_fail++; $display("FAIL rand_rack_%0d got rack=%b wack=%b want port %0d", n, rk, wk, exp_idx); end
         end
         for (int i = 0; i < NR; i++) begin
            n_checks++; if (c_dout[i*DATA_W +: DATA_W] !== exp_lane[i]) begin n_fail++; $display("FAIL rand_lane_%0d_%0d got %h want %h", n, i, c_dout[i*DATA_W +: DATA_W], exp_lane[i]); end
         end
         step();
         n_checks++; if (c_rack !== '0 || c_wack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle_%0d got rack=%b wack=%b busy=%b", n, c_rack, c_wack, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_starve();
      test_simultaneous();
      test_reset_mid_read();
      test_stray_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory read/write channel between NR cache read requesters and one write requester.
- Serialises transactions with exactly one outstanding at a time.
- Read ports are served round-robin; the write port has priority, bounded by an anti-starvation counter.
- Sits between the caches and the memory/UART controller; all handshakes are fully synchronous.

Parameters:
- NR, 2: number of read requester ports (>=2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LEN_W, 2: length field width (encoded as bytes-1).
- WR_STARVE_MAX, 4: consecutive write grants allowed while any read is pending (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- c_re  in  NR  per-port read request (level).
- c_raddr  in  NR*ADDR_W  per-port read address; port i occupies [(i+1)*ADDR_W-1 : i*ADDR_W].
- c_rlen  in  NR*LEN_W  per-port read length.
- c_dout  out  NR*DATA_W  per-port read data.
- c_rack  out  NR  per-port read ack (1-cycle pulse).
- c_we  in  1  write request (level).
- c_waddr  in  ADDR_W  write address.
- c_wlen  in  LEN_W  write length.
- c_din  in  DATA_W  write data.
- c_wack  out  1  write ack (1-cycle pulse).
- m_re  out  1  memory read enable.
- m_raddr  out  ADDR_W  memory read address.
- m_rlen  out  LEN_W  memory read length.
- m_din  in  DATA_W  memory read data.
- m_rack  in  1  memory read done.
- m_we  out  1  memory write enable.
- m_waddr  out  ADDR_W  memory write address.
- m_wlen  out  LEN_W  memory write length.
- m_dout  out  DATA_W  memory write data.
- m_wack  in  1  memory write done.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0, including every c_dout lane; state=IDLE; rr_ptr=NR-1 (port 0 wins first); wr_streak=0. rst mid-transaction aborts it: no ack is issued, m_re/m_we drop in the next cycle, and any late m_rack/m_wack is ignored.
- Registered outputs: all outputs are registered.
- States: IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP.
- IDLE arbitration, evaluated on the current cycle's requests:
  - Write only pending: grant the write.
  - Reads only pending: grant the first asserted c_re[i] searching circularly from rr_ptr+1.
  - Both pending and wr_streak < WR_STARVE_MAX: grant the write; wr_streak++.
  - Both pending and wr_streak == WR_STARVE_MAX: grant the round-robin read.
  - Any read grant: wr_streak=0, rr_ptr=granted index.
  - Write granted with no read pending: wr_streak unchanged.
- Read grant: latch port index; m_raddr/m_rlen take that port's lane; m_re=1 from the next cycle; go to R_WAIT.
- R_WAIT: hold m_re and the address/length stable until m_rack=1 is sampled. Then:
  - c_dout lane[port] <= m_din;
  - m_re <= 0;
  - c_rack[port] <= 1;
  - go to R_RESP.
- R_RESP: single cycle with c_rack[port] high; then c_rack <= 0 and go to IDLE.
- Write path: same sequence using m_we/m_waddr/m_wlen/m_dout (captured from c_waddr/c_wlen/c_din at grant), W_WAIT waiting on m_wack, and c_wack high during W_RESP.
- Requester contract:
  - Hold req and operands stable until ack is seen.
  - On the edge where ack=1, either drop req or present a new request. IDLE treats any req still high as a new request.
  - A port whose ack is high is never double-granted, because RESP always precedes IDLE.
- Minimum latency: req high at cycle 0 (IDLE); m_re high at cycle 1; m_rack at cycle 1 gives c_rack at cycle 2; IDLE at cycle 3. Throughput is at most 1 transaction per 3 cycles.
- c_dout lanes: each lane holds its value until the next completed read for that port; other lanes are unaffected.
- Stray acks: m_rack outside R_WAIT and m_wack outside W_WAIT are ignored.
- Mid-transaction requests: requests arriving during a transaction wait; requests dropped before grant are forgotten (no queue).
- Width rules: c_rlen/c_wlen pass through unmodified; no address arithmetic is performed.

Test Plan:
1. Single read: c_re=01, c_raddr[0]=0x100, c_rlen[0]=3, memory acks after 2 cycles with m_din=0xDEADBEEF -> m_raddr=0x100, m_rlen=3, m_re high for 2 cycles; c_dout lane0=0xDEADBEEF; c_rack=01 for exactly 1 cycle; lane1 stays 0.
2. Round-robin: c_re=11 held continuously, memory acks in 1 cycle -> grant order is port 0, 1, 0, 1; acks alternate 01, 10, 01, 10; every transaction is 3 cycles apart.
3. Write priority and starvation with WR_STARVE_MAX=4: c_we and c_re[0] held -> 4 writes, then 1 read, then 4 writes; wr_streak is 0 after the read.
4. Simultaneous write and read after reset: c_we and c_re=10 asserted in the same cycle -> write granted first (m_we, c_wack), then port 1 read.
5. Reset mid-read: rst pulsed during R_WAIT, m_rack arriving afterwards -> m_re=0, c_rack stays 0, c_dout all 0, busy=0, state IDLE; the next request is served normally.
6. Stray ack: m_rack=1 and m_wack=1 pulsed in IDLE with no requests -> no ack outputs, busy stays 0.
